// File: rtl/thd_frame_ctrl.sv
// Frame controller for the THD measurement path.
// Collects FRAME_LEN consecutive ADC samples into a downstream shift register,
// waits for the register to report full, then starts the THD computation and
// counts completed frames. Sample gaps and shift-register timeouts set sticky
// error flags. Every output is driven straight from a flop.
module thd_frame_ctrl #(
  parameter int FRAME_LEN = 32,
  parameter int DONE_TO   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic               smp_valid,
  input  logic signed [15:0] smp_data,
  output logic               sipo_arm_n,
  output logic signed [15:0] sipo_din,
  input  logic               sipo_done,
  output logic               calc_start,
  input  logic               calc_done,
  output logic               busy,
  output logic               frame_rdy,
  output logic [7:0]         frame_cnt,
  output logic [1:0]         err_flags,
  input  logic               clr_err
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TO_W  = (DONE_TO > 1) ? $clog2(DONE_TO) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DONE_TO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    FILL  = 3'd2,
    DWAIT = 3'd3,
    CALC  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               arm_n_d;
  logic signed [15:0] din_d;
  logic               calc_start_d;
  logic               frame_rdy_d;
  logic [7:0]         cnt_d;
  logic [1:0]         err_set;
  logic [1:0]         err_d;
  logic               busy_d;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    fill_d       = fill_q;
    to_d         = to_q;
    arm_n_d      = 1'b1;
    din_d        = sipo_din;
    calc_start_d = 1'b0;
    frame_rdy_d  = 1'b0;
    cnt_d        = frame_cnt;
    err_set      = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (enable || start) state_d = SYNC;
      end
      SYNC: begin
        // First valid sample arms the shift register and is presented with it.
        if (smp_valid) begin
          din_d   = smp_data;
          arm_n_d = 1'b0;
          fill_d  = CNT_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (smp_valid) begin
          din_d  = smp_data;
          fill_d = fill_q + CNT_W'(1);
          if (fill_q == LAST_IDX) begin
            fill_d  = '0;
            to_d    = '0;
            state_d = DWAIT;
          end
        end else begin
          // A missing sample breaks the frame; resynchronise on the next one.
          err_set[0] = 1'b1;
          fill_d     = '0;
          state_d    = SYNC;
        end
      end
      DWAIT: begin
        if (sipo_done) begin
          calc_start_d = 1'b1;
          state_d      = CALC;
        end else if (to_q == TO_LAST) begin
          err_set[1] = 1'b1;
          state_d    = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      CALC: begin
        if (calc_done) begin
          frame_rdy_d = 1'b1;
          cnt_d       = frame_cnt + 8'd1;
          state_d     = enable ? SYNC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A newly detected error takes priority over a simultaneous clear.
    err_d  = (err_flags & ~{2{clr_err}}) | err_set;
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      to_q       <= '0;
      sipo_arm_n <= 1'b1;
      sipo_din   <= '0;
      calc_start <= 1'b0;
      frame_rdy  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      err_flags  <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      to_q       <= to_d;
      sipo_arm_n <= arm_n_d;
      sipo_din   <= din_d;
      calc_start <= calc_start_d;
      frame_rdy  <= frame_rdy_d;
      busy       <= busy_d;
      frame_cnt  <= cnt_d;
      err_flags  <= err_d;
    end
  end

endmodule

// File: tb/tb_thd_frame_ctrl.sv
// Self-checking bench for thd_frame_ctrl. Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point. Expected values come from a
// frame-level model: the list of samples fed, the number of completed frames
// and the sticky error bits implied by gaps, timeouts and clears.
module tb_thd_frame_ctrl;

  localparam int FRAME_LEN = 32;
  localparam int DONE_TO   = 3;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        start     = 1'b0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data  = '0;
  logic        sipo_done = 1'b0;
  logic        calc_done = 1'b0;
  logic        clr_err   = 1'b0;
  logic        sipo_arm_n;
  logic [15:0] sipo_din;
  logic        calc_start;
  logic        busy;
  logic        frame_rdy;
  logic [7:0]  frame_cnt;
  logic [1:0]  err_flags;

  int          checks      = 0;
  int          failures    = 0;
  int          arm_seen    = 0;
  int          arm0        = 0;
  int          frames_done = 0;
  logic [1:0]  exp_err     = 2'b00;
  bit          en          = 1'b0;
  logic [15:0] smp [FRAME_LEN];

  thd_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .DONE_TO(DONE_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .sipo_arm_n (sipo_arm_n),
    .sipo_din   (sipo_din),
    .sipo_done  (sipo_done),
    .calc_start (calc_start),
    .calc_done  (calc_done),
    .busy       (busy),
    .frame_rdy  (frame_rdy),
    .frame_cnt  (frame_cnt),
    .err_flags  (err_flags),
    .clr_err    (clr_err)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sipo_arm_n === 1'b0) arm_seen++;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_arm_n"},     32'(sipo_arm_n), 32'd1);
    check({tag, "_din"},       32'(sipo_din),   32'd0);
    check({tag, "_calc"},      32'(calc_start), 32'd0);
    check({tag, "_rdy"},       32'(frame_rdy),  32'd0);
    check({tag, "_busy"},      32'(busy),       32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt),  32'd0);
    check({tag, "_err"},       32'(err_flags),  32'd0);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_no_arm", 32'(sipo_arm_n), 32'd1);
  endtask

  // One frame starting with the block waiting for its first sample.
  // gap_at >= 0 drops that sample (frame aborts); done_dly >= DONE_TO never
  // raises sipo_done (timeout); drop_at >= 0 lowers enable at that sample.
  task automatic do_frame(input int pre, input int gap_at, input int done_dly,
                          input int calc_dly, input int drop_at, input bit ramp,
                          input bit poke_start, input bit clr_at_gap);
    logic [15:0] last;
    for (int i = 0; i < pre; i++) begin
      smp_valid = 1'b0;
      smp_data  = 16'($urandom);
      tick();
      check("sync_wait_arm", 32'(sipo_arm_n), 32'd1);
      check("sync_wait_busy", 32'(busy), 32'd1);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == drop_at) begin
        enable = 1'b0;
        en     = 1'b0;
      end
      if (i == gap_at) begin
        smp_valid = 1'b0;
        clr_err   = clr_at_gap;
        tick();
        clr_err = 1'b0;
        exp_err = clr_at_gap ? 2'b01 : (exp_err | 2'b01);
        check("gap_err", 32'(err_flags), 32'(exp_err));
        check("gap_arm", 32'(sipo_arm_n), 32'd1);
        check("gap_hold", 32'(sipo_din), 32'(smp[i-1]));
        check("gap_no_calc", 32'(calc_start), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        return;
      end
      smp[i]    = ramp ? 16'(i) : 16'($urandom);
      smp_valid = 1'b1;
      smp_data  = smp[i];
      tick();
      check("fill_arm", 32'(sipo_arm_n), (i == 0) ? 32'd0 : 32'd1);
      check("fill_din", 32'(sipo_din), 32'(smp[i]));
      check("fill_busy", 32'(busy), 32'd1);
      check("fill_no_calc", 32'(calc_start), 32'd0);
    end
    last = smp[FRAME_LEN-1];
    for (int i = 0; i < done_dly && i < DONE_TO; i++) begin
      smp_valid = 1'($urandom);
      smp_data  = 16'($urandom);
      tick();
      if (i == DONE_TO - 1) exp_err[1] = 1'b1;
      check("dwait_din_hold", 32'(sipo_din), 32'(last));
      check("dwait_no_calc", 32'(calc_start), 32'd0);
      check("dwait_err", 32'(err_flags), 32'(exp_err));
      check("dwait_busy", 32'(busy), (i == DONE_TO - 1) ? 32'd0 : 32'd1);
    end
    if (done_dly >= DONE_TO) begin
      smp_valid = 1'b0;
      return;
    end
    sipo_done = 1'b1;
    smp_valid = 1'($urandom);
    smp_data  = 16'($urandom);
    tick();
    sipo_done = 1'b0;
    check("calc_start_pulse", 32'(calc_start), 32'd1);
    check("calc_start_no_rdy", 32'(frame_rdy), 32'd0);
    check("calc_din_hold", 32'(sipo_din), 32'(last));
    for (int c = 0; c < calc_dly; c++) begin
      start     = poke_start;
      smp_valid = 1'($urandom);
      smp_data  = 16'($urandom);
      tick();
      start = 1'b0;
      check("calc_single_pulse", 32'(calc_start), 32'd0);
      check("calc_wait_rdy", 32'(frame_rdy), 32'd0);
      check("calc_wait_busy", 32'(busy), 32'd1);
      check("calc_din_hold", 32'(sipo_din), 32'(last));
      check("calc_wait_cnt", 32'(frame_cnt), 32'(frames_done % 256));
    end
    calc_done = 1'b1;
    smp_valid = 1'($urandom);
    tick();
    calc_done = 1'b0;
    frames_done++;
    check("frame_rdy", 32'(frame_rdy), 32'd1);
    check("frame_cnt", 32'(frame_cnt), 32'(frames_done % 256));
    check("frame_end_busy", 32'(busy), 32'(en));
    check("frame_end_err", 32'(err_flags), 32'(exp_err));
    check("frame_end_calc", 32'(calc_start), 32'd0);
    smp_valid = en ? 1'b0 : 1'($urandom);
    tick();
    smp_valid = 1'b0;
    check("rdy_single_pulse", 32'(frame_rdy), 32'd0);
    check("post_frame_arm", 32'(sipo_arm_n), 32'd1);
    check("post_frame_busy", 32'(busy), 32'(en));
  endtask

  initial begin
    // Power-on reset, released between clock edges.
    tick();
    tick();
    check_reset("por");
    #2 rst_n = 1'b1;
    tick();
    check_reset("post_release");

    // Single-shot frame with ramp data 0..31.
    start_pulse();
    do_frame(2, -1, 1, 2, -1, 1'b1, 1'b0, 1'b0);
    check("single_cnt", 32'(frame_cnt), 32'd1);

    // Randomised single-shot frames; odd ones pulse start during CALC.
    for (int f = 0; f < 4; f++) begin
      start_pulse();
      do_frame(int'($urandom_range(0, 3)), -1, int'($urandom_range(0, DONE_TO - 1)),
               int'($urandom_range(1, 4)), -1, 1'b0, (f % 2) == 1, 1'b0);
    end

    // Sample gap at sample 10, then a full frame from the next valid sample.
    start_pulse();
    do_frame(0, 10, 0, 0, -1, 1'b1, 1'b0, 1'b0);
    do_frame(0, -1, int'($urandom_range(0, DONE_TO - 1)), 2, -1, 1'b0, 1'b0, 1'b0);
    check("gap_err_sticky", 32'(err_flags), 32'd1);

    // Gap coinciding with clr_err: the new error must survive the clear.
    start_pulse();
    do_frame(1, int'($urandom_range(1, FRAME_LEN - 2)), 0, 0, -1, 1'b0, 1'b0, 1'b1);
    do_frame(0, -1, 0, 1, -1, 1'b0, 1'b0, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_err = 2'b00;
    check("clr_after_gap", 32'(err_flags), 32'd0);

    // Shift-register timeout, then stray done strobes in IDLE.
    start_pulse();
    do_frame(0, -1, DONE_TO, 0, -1, 1'b0, 1'b0, 1'b0);
    check("timeout_err", 32'(err_flags), 32'd2);
    sipo_done = 1'b1;
    calc_done = 1'b1;
    tick();
    sipo_done = 1'b0;
    calc_done = 1'b0;
    check("stray_done_calc", 32'(calc_start), 32'd0);
    check("stray_done_rdy", 32'(frame_rdy), 32'd0);
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_cnt", 32'(frame_cnt), 32'(frames_done % 256));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_err = 2'b00;
    check("clr_after_timeout", 32'(err_flags), 32'd0);

    // Continuous mode: three frames, enable dropped inside the third.
    arm0   = arm_seen;
    enable = 1'b1;
    en     = 1'b1;
    tick();
    check("cont_busy", 32'(busy), 32'd1);
    do_frame(int'($urandom_range(0, 2)), -1, int'($urandom_range(0, DONE_TO - 1)), 5, -1, 1'b0, 1'b0, 1'b0);
    do_frame(0, -1, int'($urandom_range(0, DONE_TO - 1)), 5, -1, 1'b0, 1'b0, 1'b0);
    do_frame(0, -1, int'($urandom_range(0, DONE_TO - 1)), 5, 15, 1'b0, 1'b0, 1'b0);
    check("cont_arm_pulses", 32'(arm_seen - arm0), 32'd3);
    check("cont_idle_after", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a fill.
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      smp[i]    = 16'($urandom);
      smp_valid = 1'b1;
      smp_data  = smp[i];
      tick();
      check("prerst_din", 32'(sipo_din), 32'(smp[i]));
    end
    smp_data = 16'($urandom);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    frames_done = 0;
    exp_err     = 2'b00;
    tick();
    check_reset("rst_held");
    #2 rst_n = 1'b1;
    arm0 = arm_seen;
    for (int i = 0; i < 4; i++) begin
      smp_valid = 1'b1;
      smp_data  = 16'($urandom);
      tick();
      check("post_rst_arm", 32'(sipo_arm_n), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    smp_valid = 1'b0;
    check("post_rst_no_pulse", 32'(arm_seen - arm0), 32'd0);
    start_pulse();
    do_frame(1, -1, 0, 3, -1, 1'b0, 1'b0, 1'b0);
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // Counter wrap: 255 more frames make 256 since reset.
    enable = 1'b1;
    en     = 1'b1;
    tick();
    for (int f = 0; f < 255; f++) begin
      do_frame(0, -1, 0, 0, (f == 254) ? 5 : -1, 1'b0, 1'b0, 1'b0);
    end
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
